// File: rtl/bnn_seq_ctrl.sv
// -----------------------------------------------------------------------------
// bnn_seq_ctrl
// Sequencer that sits in front of the 8-8-4 XNOR-popcount BNN datapath.
// It does two mutually exclusive jobs:
//   * Weight load: accepts a 4-bit nibble stream (low nibble first, then high
//     nibble) and turns each pair into one 8-bit weight write, walking the
//     neuron index from 0 to NUM_NEURONS-1.
//   * Inference: latches one input vector and waits out the datapath pipeline.
//     It then captures the 4-bit result and raises a one-cycle valid pulse.
// Because the two jobs never overlap, weights cannot change under a running
// inference.
//
// Ports
//   clk_i          rising-edge clock
//   reset_i        asynchronous active-high reset
//   ena_i          global enable; 0 freezes every state register and counter
//   load_start_i   begin, or restart, a weight-load session
//   nib_valid_i    nibble stream valid
//   nib_data_i     nibble stream data
//   nib_ready_o    nibble stream ready (combinational)
//   wr_en_o        one-cycle weight write strobe
//   wr_addr_o      neuron index being written
//   wr_data_o      {hi_nibble, lo_nibble}
//   load_busy_o    high while a load session is in progress
//   load_done_o    one-cycle pulse on the last write of a session
//   infer_req_i    request one inference on in_data_i
//   in_data_i      input vector, sampled when the request is accepted
//   x_out_o        held input vector for datapath layer 1
//   res_in_i       registered layer-2 output of the datapath
//   res_out_o      captured result, held until the next capture
//   res_valid_o    one-cycle pulse when res_out_o is updated
// -----------------------------------------------------------------------------
module bnn_seq_ctrl #(
  parameter int NUM_NEURONS = 12,
  parameter int ADDR_W      = 4,
  parameter int PIPE_LAT    = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              ena_i,
  input  logic              load_start_i,
  input  logic              nib_valid_i,
  input  logic [3:0]        nib_data_i,
  output logic              nib_ready_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o,
  output logic              load_busy_o,
  output logic              load_done_o,
  input  logic              infer_req_i,
  input  logic [7:0]        in_data_i,
  output logic [7:0]        x_out_o,
  input  logic [3:0]        res_in_i,
  output logic [3:0]        res_out_o,
  output logic              res_valid_o
);

  localparam int LAT_W = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_LO    = 2'd1,
    LOAD_HI    = 2'd2,
    INFER_WAIT = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [3:0]          lo_buf_q, lo_buf_d;
  logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic                load_done_q, load_done_d;
  logic [7:0]          x_out_q, x_out_d;
  logic [3:0]          res_out_q, res_out_d;
  logic                res_valid_q, res_valid_d;
  logic                nib_accept;

  // Ready only in the load states and only while enabled, so a disabled
  // cycle can never consume a nibble.
  assign nib_ready_o = ena_i && ((state_q == LOAD_LO) || (state_q == LOAD_HI));
  assign nib_accept  = nib_valid_i && nib_ready_o;
  assign load_busy_o = (state_q == LOAD_LO) || (state_q == LOAD_HI);

  // Next-state and registered-output logic. The pulse strobes default to 0
  // every cycle, including disabled ones; everything else holds unless the
  // block is enabled and the current state updates it.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    lo_buf_d    = lo_buf_q;
    lat_cnt_d   = lat_cnt_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    load_done_d = 1'b0;
    x_out_d     = x_out_q;
    res_out_d   = res_out_q;
    res_valid_d = 1'b0;

    if (ena_i) begin
      unique case (state_q)
        IDLE: begin
          // A load request beats a simultaneous inference request.
          if (load_start_i) begin
            idx_d   = '0;
            state_d = LOAD_LO;
          end else if (infer_req_i) begin
            x_out_d   = in_data_i;
            lat_cnt_d = LAT_W'(PIPE_LAT);
            state_d   = INFER_WAIT;
          end
        end

        LOAD_LO: begin
          if (load_start_i) begin
            idx_d   = '0;
            state_d = LOAD_LO;
          end else if (nib_accept) begin
            lo_buf_d = nib_data_i;
            state_d  = LOAD_HI;
          end
        end

        LOAD_HI: begin
          // A restart discards the buffered low nibble and suppresses the
          // write even if a nibble is handshaken in the same cycle.
          if (load_start_i) begin
            idx_d   = '0;
            state_d = LOAD_LO;
          end else if (nib_accept) begin
            wr_en_d   = 1'b1;
            wr_addr_d = idx_q;
            wr_data_d = {nib_data_i, lo_buf_q};
            if (idx_q == ADDR_W'(NUM_NEURONS - 1)) begin
              load_done_d = 1'b1;
              idx_d       = '0;
              state_d     = IDLE;
            end else begin
              idx_d   = idx_q + ADDR_W'(1);
              state_d = LOAD_LO;
            end
          end
        end

        INFER_WAIT: begin
          // Count down the pipeline stages, then sample the result on the
          // following enabled edge.
          if (lat_cnt_q != '0) begin
            lat_cnt_d = lat_cnt_q - LAT_W'(1);
          end else begin
            res_out_d   = res_in_i;
            res_valid_d = 1'b1;
            state_d     = IDLE;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers with asynchronous reset to the idle state.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      lo_buf_q    <= '0;
      lat_cnt_q   <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      load_done_q <= 1'b0;
      x_out_q     <= '0;
      res_out_q   <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      lo_buf_q    <= lo_buf_d;
      lat_cnt_q   <= lat_cnt_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      load_done_q <= load_done_d;
      x_out_q     <= x_out_d;
      res_out_q   <= res_out_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign wr_en_o     = wr_en_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign load_done_o = load_done_q;
  assign x_out_o     = x_out_q;
  assign res_out_o   = res_out_q;
  assign res_valid_o = res_valid_q;

endmodule

// File: tb/tb_bnn_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bnn_seq_ctrl
// Directed bench for the BNN sequencer. A transaction-level reference tracks
// "loading or not", how many nibbles of the session have arrived, and how many
// enabled edges remain before an inference result is taken. A compare process
// checks every DUT output against it on each falling edge. Inline literal
// checks pin the reference to hand-computed values.
// -----------------------------------------------------------------------------
module tb_bnn_seq_ctrl;

  localparam int NUM_NEURONS = 12;
  localparam int ADDR_W      = 4;
  localparam int PIPE_LAT    = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              ena = 1'b1;
  logic              load_start = 1'b0;
  logic              nib_valid = 1'b0;
  logic [3:0]        nib_data = '0;
  logic              nib_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              load_busy;
  logic              load_done;
  logic              infer_req = 1'b0;
  logic [7:0]        in_data = '0;
  logic [7:0]        x_out;
  logic [3:0]        res_in = '0;
  logic [3:0]        res_out;
  logic              res_valid;

  int total = 0;
  int bad   = 0;

  bnn_seq_ctrl #(
    .NUM_NEURONS(NUM_NEURONS),
    .ADDR_W     (ADDR_W),
    .PIPE_LAT   (PIPE_LAT)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .ena_i       (ena),
    .load_start_i(load_start),
    .nib_valid_i (nib_valid),
    .nib_data_i  (nib_data),
    .nib_ready_o (nib_ready),
    .wr_en_o     (wr_en),
    .wr_addr_o   (wr_addr),
    .wr_data_o   (wr_data),
    .load_busy_o (load_busy),
    .load_done_o (load_done),
    .infer_req_i (infer_req),
    .in_data_i   (in_data),
    .x_out_o     (x_out),
    .res_in_i    (res_in),
    .res_out_o   (res_out),
    .res_valid_o (res_valid)
  );

  // 10 time-unit clock.
  always #5 clk = ~clk;

  // Reference state: a session is described by its nibble count, and an
  // inference by the number of enabled edges left until the capture edge.
  bit         mLoading   = 1'b0;
  int         mNibCount  = 0;
  logic [3:0] mLoNib     = '0;
  int         mInferLeft = 0;
  logic       mWrEn      = 1'b0;
  logic [3:0] mWrAddr    = '0;
  logic [7:0] mWrData    = '0;
  logic       mDone      = 1'b0;
  logic [7:0] mX         = '0;
  logic [3:0] mRes       = '0;
  logic       mResValid  = 1'b0;

  // Advance the reference on every edge using the inputs seen at that edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mLoading = 1'b0; mNibCount = 0; mLoNib = '0; mInferLeft = 0;
      mWrEn = 1'b0; mWrAddr = '0; mWrData = '0; mDone = 1'b0;
      mX = '0; mRes = '0; mResValid = 1'b0;
    end else begin
      mWrEn = 1'b0; mDone = 1'b0; mResValid = 1'b0;
      if (ena) begin
        if (mLoading) begin
          if (load_start) begin
            mNibCount = 0;
          end else if (nib_valid) begin
            if (mNibCount % 2 == 0) begin
              mLoNib = nib_data;
            end else begin
              mWrEn   = 1'b1;
              mWrAddr = 4'(mNibCount / 2);
              mWrData = {nib_data, mLoNib};
              if (mNibCount == 2 * NUM_NEURONS - 1) begin
                mDone    = 1'b1;
                mLoading = 1'b0;
              end
            end
            mNibCount = mLoading ? mNibCount + 1 : 0;
          end
        end else if (mInferLeft > 0) begin
          if (mInferLeft == 1) begin
            mRes      = res_in;
            mResValid = 1'b1;
          end
          mInferLeft = mInferLeft - 1;
        end else if (load_start) begin
          mLoading  = 1'b1;
          mNibCount = 0;
        end else if (infer_req) begin
          mX         = in_data;
          mInferLeft = PIPE_LAT + 1;
        end
      end
    end
  end

  // Single comparison point used by every check in the bench.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got=%0h want=%0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle compare of all outputs against the reference.
  always @(negedge clk) begin
    checkOutput("nib_ready", 32'(nib_ready), 32'(ena & mLoading));
    checkOutput("load_busy", 32'(load_busy), 32'(mLoading));
    checkOutput("wr_en",     32'(wr_en),     32'(mWrEn));
    checkOutput("wr_addr",   32'(wr_addr),   32'(mWrAddr));
    checkOutput("wr_data",   32'(wr_data),   32'(mWrData));
    checkOutput("load_done", 32'(load_done), 32'(mDone));
    checkOutput("x_out",     32'(x_out),     32'(mX));
    checkOutput("res_out",   32'(res_out),   32'(mRes));
    checkOutput("res_valid", 32'(res_valid), 32'(mResValid));
  end

  // Drive one cycle of inputs, let one rising edge pass, return just after
  // the following falling edge, when outputs are settled.
  task automatic applyStimulus(input logic ls, input logic nv, input logic [3:0] nd,
                               input logic ir, input logic [7:0] id);
    load_start = ls;
    nib_valid  = nv;
    nib_data   = nd;
    infer_req  = ir;
    in_data    = id;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // Assert reset mid-cycle and pin the all-zero reset state.
  task automatic doReset(input string tag);
    reset = 1'b1;
    #2;
    checkOutput({tag, "_rst_ready"}, 32'(nib_ready), 32'h0);
    checkOutput({tag, "_rst_busy"},  32'(load_busy), 32'h0);
    checkOutput({tag, "_rst_x"},     32'(x_out),     32'h0);
    checkOutput({tag, "_rst_wdata"}, 32'(wr_data),   32'h0);
    checkOutput({tag, "_rst_waddr"}, 32'(wr_addr),   32'h0);
    checkOutput({tag, "_rst_res"},   32'(res_out),   32'h0);
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  int wrCount;
  int firstStep;
  int lastStep;
  int doneAddr;
  int latency;
  int pulses;

  initial begin
    @(negedge clk);
    #1;
    doReset("init");

    // Reset while waiting for the high nibble of neuron 5.
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 8'h00);
    for (int i = 0; i < 11; i++)
      applyStimulus(1'b0, 1'b1, 4'(i), 1'b0, 8'h00);
    checkOutput("midload_busy", 32'(load_busy), 32'h1);
    checkOutput("midload_addr", 32'(wr_addr),   32'h4);
    doReset("midload");

    // Full back-to-back load of 0xE0 into all neurons.
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 8'h00);
    wrCount = 0; firstStep = -1; lastStep = -1; doneAddr = -1;
    for (int i = 0; i < 2 * NUM_NEURONS; i++) begin
      applyStimulus(1'b0, 1'b1, (i % 2 == 0) ? 4'h0 : 4'hE, 1'b0, 8'h00);
      if (wr_en) begin
        wrCount++;
        if (firstStep < 0) firstStep = i;
        lastStep = i;
        checkOutput("load_data", 32'(wr_data), 32'hE0);
        if (load_done) doneAddr = int'(wr_addr);
      end
    end
    checkOutput("load_writes", 32'(wrCount), 32'd12);
    checkOutput("load_span",   32'(lastStep - firstStep), 32'd22);
    checkOutput("load_doneaddr", 32'(doneAddr), 32'd11);
    checkOutput("load_idle",   32'(load_busy), 32'h0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 8'h00);

    // Stall after a low nibble: valid low, then disabled with data offered.
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 4'h3, 1'b0, 8'h00);
    wrCount = 0;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 8'h00);
      if (wr_en) wrCount++;
    end
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 4'hC, 1'b0, 8'h00);
      if (wr_en) wrCount++;
    end
    checkOutput("stall_nowrite", 32'(wrCount), 32'd0);
    ena = 1'b1;
    applyStimulus(1'b0, 1'b1, 4'hC, 1'b0, 8'h00);
    checkOutput("stall_wr_en",   32'(wr_en),   32'h1);
    checkOutput("stall_wr_data", 32'(wr_data), 32'hC3);
    checkOutput("stall_wr_addr", 32'(wr_addr), 32'h0);

    // Restart while in the high-nibble phase: no write that cycle.
    applyStimulus(1'b0, 1'b1, 4'h7, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 4'h9, 1'b0, 8'h00);
    checkOutput("restart_nowrite", 32'(wr_en),     32'h0);
    checkOutput("restart_ready",   32'(nib_ready), 32'h1);
    applyStimulus(1'b0, 1'b1, 4'h1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 4'h2, 1'b0, 8'h00);
    checkOutput("restart_addr", 32'(wr_addr), 32'h0);
    checkOutput("restart_data", 32'(wr_data), 32'h21);
    doReset("postload");

    // Single inference on 0xE0.
    res_in = 4'h0;
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 8'hE0);
    checkOutput("infer_x", 32'(x_out), 32'hE0);
    res_in  = 4'h5;
    latency = 0;
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 8'h00);
      latency = k;
      if (res_valid) break;
    end
    checkOutput("infer_latency", 32'(latency), 32'd3);
    checkOutput("infer_res",     32'(res_out), 32'h5);

    // Inference stretched by three disabled cycles.
    res_in = 4'hA;
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 8'h81);
    ena = 1'b0;
    for (int k = 0; k < 3; k++)
      applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 8'h00);
    ena = 1'b1;
    latency = 3;
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 8'h00);
      latency = 3 + k;
      if (res_valid) break;
    end
    checkOutput("stretch_latency", 32'(latency), 32'd6);
    checkOutput("stretch_res",     32'(res_out), 32'hA);

    // Load and inference requested together: load wins.
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b1, 8'h55);
    checkOutput("both_x",     32'(x_out),     32'h81);
    checkOutput("both_busy",  32'(load_busy), 32'h1);
    checkOutput("both_valid", 32'(res_valid), 32'h0);
    doReset("both");

    // Requests during an inference are ignored.
    res_in = 4'h9;
    pulses = 0;
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 8'h3C);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 8'hFF);
    if (res_valid) pulses++;
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 8'h00);
    if (res_valid) pulses++;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 8'h00);
      if (res_valid) pulses++;
    end
    checkOutput("ignore_pulses", 32'(pulses),    32'd1);
    checkOutput("ignore_x",      32'(x_out),     32'h3C);
    checkOutput("ignore_res",    32'(res_out),   32'h9);
    checkOutput("ignore_idle",   32'(load_busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
